// File: rtl/i2c_temp_slave.sv
// I2C read-only temperature sensor responder: ACKs address+R for DEV_ADDR, then serves MSB, LSB, MSB... until NACK.
// Optional I2C_SLV_SNAPSHOT_EN: latch {temp_msb,temp_lsb} at address ACK so every byte of a read is coherent.
module i2c_temp_slave #(
   parameter logic [6:0] DEV_ADDR = 7'h4B
) (
   input  logic       clk_200KHz,
   input  logic       rst_n,
   input  logic       SCL,
   inout  wire        SDA,
   input  logic [7:0] temp_msb,
   input  logic [7:0] temp_lsb,
   output logic       busy,
   output logic       rd_done
);

   // state      | meaning
   // S_IDLE     | bus free, waiting for START
   // S_ADDR     | shifting in address byte
   // S_ADDR_ACK | driving ACK for our address
   // S_TX_BYTE  | driving data bits, one per SCL fall
   // S_RX_MACK  | sampling master ACK/NACK
   // S_IGNORE   | not addressed, wait for START/STOP
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_TX_BYTE, S_RX_MACK, S_IGNORE
   } state_t;

   state_t     r_state, w_state_nxt;
   logic       r_scl_s1, r_scl_s2, r_scl_prev;
   logic       r_sda_s1, r_sda_s2, r_sda_prev;
   logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic [7:0] r_tx, w_tx_nxt;
   logic       r_sda_low, w_sda_low_nxt;
   logic       r_byte_sel, w_byte_sel_nxt;
   logic       r_acked, w_acked_nxt;
   logic       r_rd_done, w_rd_done_nxt;
   logic [7:0] w_byte;
   logic       w_scl_rise, w_scl_fall, w_start, w_stop;

`ifdef I2C_SLV_SNAPSHOT_EN
   logic [15:0] r_shadow, w_shadow_nxt;
   assign w_byte = r_byte_sel ? r_shadow[7:0] : r_shadow[15:8];
`else
   assign w_byte = r_byte_sel ? temp_lsb : temp_msb;
`endif

   // Synchronisers reset to 1 so an idle bus looks idle immediately after reset.
   always_ff @(posedge clk_200KHz or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_s1   <= 1'b1;
         r_scl_s2   <= 1'b1;
         r_scl_prev <= 1'b1;
         r_sda_s1   <= 1'b1;
         r_sda_s2   <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_s1   <= SCL;
         r_scl_s2   <= r_scl_s1;
         r_scl_prev <= r_scl_s2;
         r_sda_s1   <= SDA;
         r_sda_s2   <= r_sda_s1;
         r_sda_prev <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
   assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
   assign w_start    = r_scl_s2 & r_scl_prev & r_sda_prev & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & r_scl_prev & ~r_sda_prev & r_sda_s2;

   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_tx_nxt       = r_tx;
      w_sda_low_nxt  = r_sda_low;
      w_byte_sel_nxt = r_byte_sel;
      w_acked_nxt    = r_acked;
      w_rd_done_nxt  = 1'b0;
`ifdef I2C_SLV_SNAPSHOT_EN
      w_shadow_nxt   = r_shadow;
`endif
      if (w_start) begin
         w_state_nxt    = S_ADDR;
         w_bit_cnt_nxt  = 4'd0;
         w_sda_low_nxt  = 1'b0;
         w_byte_sel_nxt = 1'b0;
      end else if (w_stop) begin
         w_state_nxt   = S_IDLE;
         w_sda_low_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = {r_shift[6:0], r_sda_s2};
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                  if (r_shift == {DEV_ADDR, 1'b1}) begin
                     w_state_nxt   = S_ADDR_ACK;
                     w_sda_low_nxt = 1'b1;
`ifdef I2C_SLV_SNAPSHOT_EN
                     w_shadow_nxt  = {temp_msb, temp_lsb};
`endif
                  end else begin
                     w_state_nxt   = S_IGNORE;
                     w_sda_low_nxt = 1'b0;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_state_nxt   = S_TX_BYTE;
                  w_tx_nxt      = w_byte;
                  w_sda_low_nxt = ~w_byte[7];
                  w_bit_cnt_nxt = 4'd0;
               end
            end
            S_TX_BYTE: begin
               if (w_scl_fall) begin
                  if (r_bit_cnt == 4'd7) begin
                     w_state_nxt   = S_RX_MACK;
                     w_sda_low_nxt = 1'b0;
                     w_acked_nxt   = 1'b0;
                  end else begin
                     w_tx_nxt      = {r_tx[6:0], 1'b0};
                     w_sda_low_nxt = ~r_tx[6];
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end
            end
            S_RX_MACK: begin
               if (w_scl_rise) begin
                  if (!r_sda_s2) begin
                     w_acked_nxt    = 1'b1;
                     w_byte_sel_nxt = ~r_byte_sel;
                  end else begin
                     w_rd_done_nxt  = 1'b1;
                     w_state_nxt    = S_IGNORE;
                     w_byte_sel_nxt = 1'b0;
                  end
               end else if (w_scl_fall && r_acked) begin
                  w_state_nxt   = S_TX_BYTE;
                  w_tx_nxt      = w_byte;
                  w_sda_low_nxt = ~w_byte[7];
                  w_bit_cnt_nxt = 4'd0;
               end
            end
            default: w_sda_low_nxt = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_200KHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= 4'd0;
         r_shift    <= 8'd0;
         r_tx       <= 8'd0;
         r_sda_low  <= 1'b0;
         r_byte_sel <= 1'b0;
         r_acked    <= 1'b0;
         r_rd_done  <= 1'b0;
`ifdef I2C_SLV_SNAPSHOT_EN
         r_shadow   <= 16'd0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
         r_sda_low  <= w_sda_low_nxt;
         r_byte_sel <= w_byte_sel_nxt;
         r_acked    <= w_acked_nxt;
         r_rd_done  <= w_rd_done_nxt;
`ifdef I2C_SLV_SNAPSHOT_EN
         r_shadow   <= w_shadow_nxt;
`endif
      end
   end

   assign SDA     = r_sda_low ? 1'b0 : 1'bz;
   assign busy    = (r_state == S_ADDR_ACK) || (r_state == S_TX_BYTE) || (r_state == S_RX_MACK);
   assign rd_done = r_rd_done;

endmodule

// File: tb/tb_i2c_temp_slave.sv
// Bench for i2c_temp_slave: bit-level I2C master, expected bytes queued at stimulus time and popped on read.
`timescale 1ns/1ns
module tb_i2c_temp_slave;

   logic       clk_200KHz = 1'b0;
   logic       rst_n      = 1'b0;
   logic       scl        = 1'b1;
   logic       m_sda_low  = 1'b0;
   logic [7:0] temp_msb   = 8'h19;
   logic [7:0] temp_lsb   = 8'h80;
   logic       busy, rd_done;
   wire        sda_bus;

   pullup (sda_bus);
   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

   i2c_temp_slave #(.DEV_ADDR(7'h4B)) dut (
      .clk_200KHz (clk_200KHz),
      .rst_n      (rst_n),
      .SCL        (scl),
      .SDA        (sda_bus),
      .temp_msb   (temp_msb),
      .temp_lsb   (temp_lsb),
      .busy       (busy),
      .rd_done    (rd_done)
   );

   always #2500 clk_200KHz = ~clk_200KHz;

   int         n_chk = 0;
   int         n_err = 0;
   int         rd_cnt = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk_200KHz) if (rd_done) rd_cnt <= rd_cnt + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_200KHz);
   endtask

   // All bit tasks start and end with SCL low (except from the idle bus).
   task automatic m_start();
      m_sda_low = 1'b0; tick(5);
      scl = 1'b1;       tick(5);
      m_sda_low = 1'b1; tick(5);
      scl = 1'b0;       tick(5);
   endtask

   task automatic m_stop();
      m_sda_low = 1'b1; tick(5);
      scl = 1'b1;       tick(5);
      m_sda_low = 1'b0; tick(5);
   endtask

   task automatic write_bit(input logic b);
      tick(5);
      m_sda_low = ~b; tick(5);
      scl = 1'b1;     tick(10);
      scl = 1'b0;
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; tick(10);
      scl = 1'b1;       tick(5);
      b = sda_bus;      tick(5);
      scl = 1'b0;
   endtask

   task automatic send_addr(input logic [7:0] addr, output logic ack);
      m_start();
      for (int i = 7; i >= 0; i--) write_bit(addr[i]);
      read_bit(ack);
   endtask

   task automatic do_read(input logic [7:0] addr, input int nbytes,
                          input int chg_idx, input logic [7:0] chg_val);
      logic       ack, b;
      logic [7:0] got, exp;
      int         rd_before;
      rd_before = rd_cnt;
      send_addr(addr, ack);
      chk("addr_ack", {15'd0, ack}, {15'd0, (addr == 8'h97) ? 1'b0 : 1'b1});
      chk("busy_in_read", {15'd0, busy}, 16'd1);
      for (int k = 0; k < nbytes; k++) begin
         for (int i = 7; i >= 0; i--) begin
            if (k == chg_idx && i == 3) temp_msb = chg_val;
            read_bit(b);
            got[i] = b;
         end
         if (exp_q.size() == 0) chk("sb_empty", 16'd1, 16'd0);
         else begin
            exp = exp_q.pop_front();
            chk("data_byte", {8'd0, got}, {8'd0, exp});
         end
         write_bit(k == nbytes - 1);
      end
      tick(5);
      chk("rd_done_pulses", 16'(rd_cnt - rd_before), 16'd1);
      chk("busy_after_nack", {15'd0, busy}, 16'd0);
      m_stop();
      tick(10);
   endtask

   initial begin
      logic       ack, b, all_one;
      logic [2:0] bits3;
      tick(3);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_rd_done", {15'd0, rd_done}, 16'd0);
      chk("rst_sda", {15'd0, sda_bus}, 16'd1);
      rst_n = 1'b1;
      tick(10);

      // Basic two-byte read
      exp_q.push_back(8'h19); exp_q.push_back(8'h80);
      do_read(8'h97, 2, -1, 8'h00);

      // Wrong address, then write to our address: both NACKed and ignored
      send_addr(8'h91, ack);
      chk("wrong_addr_nack", {15'd0, ack}, 16'd1);
      chk("wrong_addr_busy", {15'd0, busy}, 16'd0);
      all_one = 1'b1;
      for (int i = 0; i < 9; i++) begin read_bit(b); all_one &= b; end
      chk("ignore_sda_free", {15'd0, all_one}, 16'd1);
      send_addr(8'h96, ack);
      chk("write_addr_nack", {15'd0, ack}, 16'd1);
      chk("write_addr_busy", {15'd0, busy}, 16'd0);
      m_stop();
      tick(10);

      // Four bytes: byte_sel wraps MSB, LSB, MSB, LSB
      exp_q.push_back(8'h19); exp_q.push_back(8'h80);
      exp_q.push_back(8'h19); exp_q.push_back(8'h80);
      do_read(8'h97, 4, -1, 8'h00);

      // temp_msb changes during the LSB transfer
      exp_q.push_back(8'h19); exp_q.push_back(8'h80);
`ifdef I2C_SLV_SNAPSHOT_EN
      exp_q.push_back(8'h19);
`else
      exp_q.push_back(8'h1A);
`endif
      do_read(8'h97, 3, 1, 8'h1A);
      temp_msb = 8'h19;

      // Repeated START mid MSB transfer, then a full read serving MSB again
      send_addr(8'h97, ack);
      chk("rs_first_ack", {15'd0, ack}, 16'd0);
      for (int i = 2; i >= 0; i--) begin read_bit(b); bits3[i] = b; end
      chk("rs_partial_bits", {13'd0, bits3}, 16'd0);
      exp_q.push_back(8'h19); exp_q.push_back(8'h80);
      do_read(8'h97, 2, -1, 8'h00);

      // STOP mid-byte
      send_addr(8'h97, ack);
      for (int i = 0; i < 4; i++) read_bit(b);
      m_stop();
      tick(5);
      chk("stop_busy", {15'd0, busy}, 16'd0);
      chk("stop_sda", {15'd0, sda_bus}, 16'd1);
      tick(10);

      // Reset while the slave drives a 0 data bit
      send_addr(8'h97, ack);
      read_bit(b);
      tick(4);
      chk("pre_rst_sda_low", {15'd0, sda_bus}, 16'd0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_sda", {15'd0, sda_bus}, 16'd1);
      chk("async_rst_busy", {15'd0, busy}, 16'd0);
      tick(3);
      rst_n = 1'b1;
      tick(3);
      all_one = 1'b1;
      for (int i = 0; i < 9; i++) begin read_bit(b); all_one &= b; end
      chk("post_rst_ignore", {15'd0, all_one}, 16'd1);
      m_stop();
      tick(10);
      exp_q.push_back(8'h19); exp_q.push_back(8'h80);
      do_read(8'h97, 2, -1, 8'h00);

      chk("sb_drained", 16'(exp_q.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
